// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - load/store unit controller bridging RV32 requests to a 16-bit byte-addressed data memory
module lsu_ctrl #(
  parameter int ALLOW_MISALIGNED = 0
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [2:0]  i_req_funct3,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err,
  output logic [15:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_mask,
  output logic        o_mem_wren,
  input  logic [31:0] i_mem_rdata
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  logic [1:0]  state;
  logic [1:0]  state_nxt;

  logic        r_we;
  logic [2:0]  r_funct3;
  logic [15:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_err;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  logic [1:0]  size_m1;
  logic [16:0] last_byte;
  logic        bad_upper;
  logic        bad_funct3;
  logic        bad_align;
  logic        bad_wrap;
  logic        req_err;
  logic        access_ok;
  logic [31:0] load_ext;

  // Classify the incoming request; a faulting request still walks the FSM but never touches memory
  always_comb begin
    size_m1 = 2'd0;
    case (i_req_funct3[1:0])
      2'b01:   size_m1 = 2'd1;
      2'b10:   size_m1 = 2'd3;
      default: size_m1 = 2'd0;
    endcase
    bad_upper  = |i_req_addr[31:16];
    bad_funct3 = (i_req_funct3 == 3'b011) || (i_req_funct3[2:1] == 2'b11) ||
                 (i_req_we && i_req_funct3[2]);
    bad_align  = 1'b0;
    if (ALLOW_MISALIGNED == 0) begin
      bad_align = ((i_req_funct3[1:0] == 2'b01) && i_req_addr[0]) ||
                  ((i_req_funct3[1:0] == 2'b10) && (i_req_addr[1:0] != 2'b00));
    end
    // Carry out of the 16-bit last-byte address means the access would wrap
    last_byte = {1'b0, i_req_addr[15:0]} + {15'd0, size_m1};
    bad_wrap  = last_byte[16];
    req_err   = bad_upper || bad_funct3 || bad_align || bad_wrap;
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Next-state: one cycle in ACCESS, RESP waits for the consumer
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (i_req_valid) state_nxt = S_ACCESS;
      S_ACCESS: state_nxt = S_RESP;
      S_RESP:   if (i_rsp_ready) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs and memory drive; memory port is idle unless a good request is in ACCESS
  always_comb begin
    o_req_ready = (state == S_IDLE);
    o_rsp_valid = (state == S_RESP);
    access_ok   = (state == S_ACCESS) && !r_err;
    o_mem_addr  = access_ok ? r_addr : 16'd0;
    o_mem_wdata = access_ok ? r_wdata : 32'd0;
    o_mem_mask  = 4'b0000;
    if (access_ok) begin
      case (r_funct3[1:0])
        2'b00:   o_mem_mask = 4'b0001;
        2'b01:   o_mem_mask = 4'b0011;
        2'b10:   o_mem_mask = 4'b1111;
        default: o_mem_mask = 4'b0000;
      endcase
    end
    // Reset gates the strobe directly so a store caught by reset never lands
    o_mem_wren  = access_ok && r_we && !i_reset;
  end

  // Extend the lane-aligned memory read according to the load size
  always_comb begin
    case (r_funct3)
      3'b000:  load_ext = {{24{i_mem_rdata[7]}}, i_mem_rdata[7:0]};
      3'b001:  load_ext = {{16{i_mem_rdata[15]}}, i_mem_rdata[15:0]};
      3'b010:  load_ext = i_mem_rdata;
      3'b100:  load_ext = {24'd0, i_mem_rdata[7:0]};
      3'b101:  load_ext = {16'd0, i_mem_rdata[15:0]};
      default: load_ext = 32'd0;
    endcase
  end

  // Capture the request on accept and the response at the end of ACCESS
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_we      <= 1'b0;
      r_funct3  <= 3'd0;
      r_addr    <= 16'd0;
      r_wdata   <= 32'd0;
      r_err     <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      if ((state == S_IDLE) && i_req_valid) begin
        r_we     <= i_req_we;
        r_funct3 <= i_req_funct3;
        r_addr   <= i_req_addr[15:0];
        r_wdata  <= i_req_wdata;
        r_err    <= req_err;
      end
      if (state == S_ACCESS) begin
        rsp_err   <= r_err;
        rsp_rdata <= (!r_we && !r_err) ? load_ext : 32'd0;
      end
    end
  end

  assign o_rsp_rdata = rsp_rdata;
  assign o_rsp_err   = rsp_err;

endmodule
